mini68k_bus_arbiter: RTL and testbench

MINI68K_BUS_ARBITER -- requirements
Module: mini68k_bus_arbiter

---
 rtl/mini68k_bus_pkg.sv | 23 ++
 rtl/mini68k_rr_arbiter.sv | 33 +++
 rtl/mini68k_bus_arbiter.sv | 139 +++++++++++++
 tb/tb_mini68k_bus_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mini68k_bus_pkg.sv
// Shared definitions for the mini68k bus arbiter: FSM encodings, port indices,
// default port count and an index-width helper.
package mini68k_bus_pkg;

    localparam int unsigned NPORTS_DEFAULT = 3;

    localparam int unsigned PORT_DMA    = 0;
    localparam int unsigned PORT_IFETCH = 1;
    localparam int unsigned PORT_DATA   = 2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StDone  = 2'd3
    } arb_state_e;

    // Width of a port index; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mini68k_rr_arbiter.sv
// Winner selection: scans the request vector starting one past ptr, wrapping.
// Driving ptr with NPORTS-1 degenerates to fixed lowest-index priority.
module mini68k_rr_arbiter import mini68k_bus_pkg::*; #(
    parameter int unsigned NPORTS = NPORTS_DEFAULT,
    localparam int unsigned IW    = idx_width(NPORTS)
) (
    input  logic [NPORTS-1:0] req,
    input  logic [IW-1:0]     ptr,
    output logic [NPORTS-1:0] grant,
    output logic [IW-1:0]     index,
    output logic              valid
);

    int cand;

    // Walk offsets from farthest to nearest so the nearest requester wins last.
    always_comb begin
        grant = '0;
        index = '0;
        valid = 1'b0;
        cand  = 0;
        for (int off = int'(NPORTS); off >= 1; off--) begin
            cand = (int'(ptr) + off) % int'(NPORTS);
            if (req[cand[IW-1:0]]) begin
                grant                = '0;
                grant[cand[IW-1:0]]  = 1'b1;
                index                = cand[IW-1:0];
                valid                = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mini68k_bus_arbiter.sv
// Arbitrates NPORTS requesters onto a single bus-controller request port.
// Define MINI68K_ARB_RR_EN for round-robin; otherwise fixed priority (port 0 highest).
module mini68k_bus_arbiter import mini68k_bus_pkg::*; #(
    parameter int unsigned NPORTS = NPORTS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NPORTS-1:0]    req,
    input  logic [NPORTS-1:0]    we,
    input  logic [24*NPORTS-1:0] addr,
    input  logic [16*NPORTS-1:0] wdata,
    input  logic [NPORTS-1:0]    bsel,
    input  logic [NPORTS-1:0]    bhigh,
    output logic [NPORTS-1:0]    gnt,
    output logic [NPORTS-1:0]    done,
    output logic [15:0]          rdata,
    output logic [23:0]          bc_addr,
    output logic [15:0]          bc_wdata,
    output logic                 bc_read_req,
    output logic                 bc_write_req,
    output logic                 bc_byte_sel,
    output logic                 bc_byte_high,
    input  logic [15:0]          bc_rdata,
    input  logic                 bc_busy,
    input  logic                 bc_done
);

    localparam int unsigned IW = idx_width(NPORTS);

    arb_state_e        state;
    logic [NPORTS-1:0] cur;
    logic              is_write;
    logic [IW-1:0]     ptr;

    logic [NPORTS-1:0] win_grant;
    logic [IW-1:0]     win_index;
    logic              win_valid;

    logic              sel_we;
    logic [23:0]       sel_addr;
    logic [15:0]       sel_wdata;
    logic              sel_bsel;
    logic              sel_bhigh;

`ifndef MINI68K_ARB_RR_EN
    // Fixed priority: search always starts at port 0.
    assign ptr = IW'(NPORTS - 1);
`endif

    mini68k_rr_arbiter #(
        .NPORTS (NPORTS)
    ) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (win_grant),
        .index (win_index),
        .valid (win_valid)
    );

    // Select the winning port's operands for registration into the bus request.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_bsel  = 1'b0;
        sel_bhigh = 1'b0;
        for (int i = 0; i < int'(NPORTS); i++) begin
            if (IW'(i) == win_index) begin
                sel_we    = we[i];
                sel_addr  = addr[24*i +: 24];
                sel_wdata = wdata[16*i +: 16];
                sel_bsel  = bsel[i];
                sel_bhigh = bhigh[i];
            end
        end
    end

    // Transaction FSM; every output is registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StIdle;
            cur          <= '0;
            is_write     <= 1'b0;
            gnt          <= '0;
            done         <= '0;
            rdata        <= '0;
            bc_addr      <= '0;
            bc_wdata     <= '0;
            bc_read_req  <= 1'b0;
            bc_write_req <= 1'b0;
            bc_byte_sel  <= 1'b0;
            bc_byte_high <= 1'b0;
`ifdef MINI68K_ARB_RR_EN
            ptr          <= IW'(NPORTS - 1);
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    if (win_valid && !bc_busy) begin
                        cur          <= win_grant;
                        is_write     <= sel_we;
                        gnt          <= win_grant;
                        bc_read_req  <= !sel_we;
                        bc_write_req <= sel_we;
                        bc_addr      <= sel_addr;
                        bc_wdata     <= sel_wdata;
                        bc_byte_sel  <= sel_bsel;
                        bc_byte_high <= sel_bhigh;
`ifdef MINI68K_ARB_RR_EN
                        ptr          <= win_index;
`endif
                        state        <= StIssue;
                    end
                end
                StIssue: begin
                    gnt          <= '0;
                    bc_read_req  <= 1'b0;
                    bc_write_req <= 1'b0;
                    state        <= StWait;
                end
                StWait: begin
                    if (bc_done) begin
                        if (!is_write) begin
                            rdata <= bc_rdata;
                        end
                        done  <= cur;
                        state <= StDone;
                    end
                end
                StDone: begin
                    done  <= '0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mini68k_bus_arbiter.sv
// Directed self-checking bench for mini68k_bus_arbiter with a simple bus
// controller model that completes each request after three wait cycles.
module tb_mini68k_bus_arbiter;

    localparam int NP = 3;

    logic            clk;
    logic            rst_n;
    logic [NP-1:0]   req;
    logic [NP-1:0]   we;
    logic [24*NP-1:0] addr;
    logic [16*NP-1:0] wdata;
    logic [NP-1:0]   bsel;
    logic [NP-1:0]   bhigh;
    logic [NP-1:0]   gnt;
    logic [NP-1:0]   done;
    logic [15:0]     rdata;
    logic [23:0]     bc_addr;
    logic [15:0]     bc_wdata;
    logic            bc_read_req;
    logic            bc_write_req;
    logic            bc_byte_sel;
    logic            bc_byte_high;
    logic [15:0]     bc_rdata;
    logic            bc_busy;
    logic            bc_done;

    logic [15:0]     rd_value;
    int              bc_cnt;
    int              errors;
    int              checks;

    mini68k_bus_arbiter #(
        .NPORTS (NP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .we           (we),
        .addr         (addr),
        .wdata        (wdata),
        .bsel         (bsel),
        .bhigh        (bhigh),
        .gnt          (gnt),
        .done         (done),
        .rdata        (rdata),
        .bc_addr      (bc_addr),
        .bc_wdata     (bc_wdata),
        .bc_read_req  (bc_read_req),
        .bc_write_req (bc_write_req),
        .bc_byte_sel  (bc_byte_sel),
        .bc_byte_high (bc_byte_high),
        .bc_rdata     (bc_rdata),
        .bc_busy      (bc_busy),
        .bc_done      (bc_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bc_rdata = rd_value;

    // Bus controller model: request seen, three wait cycles, then one bc_done pulse.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bc_cnt  <= 0;
            bc_done <= 1'b0;
        end else begin
            bc_done <= 1'b0;
            if (bc_cnt != 0) begin
                bc_cnt <= bc_cnt - 1;
                if (bc_cnt == 1) bc_done <= 1'b1;
            end else if (bc_read_req || bc_write_req) begin
                bc_cnt <= 3;
            end
        end
    end

    // Bounded wait for a grant; g stays zero on timeout.
    task automatic wait_gnt(input int limit, output logic [NP-1:0] g, output int cyc);
        g   = '0;
        cyc = 0;
        while (cyc < limit && g == '0) begin
            @(negedge clk);
            cyc++;
            g = gnt;
        end
    endtask

    // Bounded wait for a completion; d stays zero on timeout.
    task automatic wait_done(input int limit, output logic [NP-1:0] d, output int cyc);
        d   = '0;
        cyc = 0;
        while (cyc < limit && d == '0) begin
            @(negedge clk);
            cyc++;
            d = done;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({gnt, done, bc_read_req, bc_write_req, bc_byte_sel, bc_byte_high} !== 10'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got gnt=%b done=%b rr=%b wr=%b bs=%b bh=%b want all 0",
                     gnt, done, bc_read_req, bc_write_req, bc_byte_sel, bc_byte_high);
        end
        checks++;
        if ({rdata, bc_addr, bc_wdata} !== 56'h0) begin
            errors++;
            $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h want 0",
                     rdata, bc_addr, bc_wdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt !== 3'b000) begin
            errors++;
            $display("FAIL idle_no_req: got gnt=%b want 000", gnt);
        end
    endtask

    task automatic test_single_read();
        logic [NP-1:0] d;
        int            cyc;
        req            = 3'b010;
        we             = 3'b000;
        addr[24 +: 24] = 24'h000100;
        rd_value       = 16'h1234;
        @(negedge clk);
        checks++;
        if (gnt !== 3'b010) begin
            errors++;
            $display("FAIL read_gnt: got %b want 010", gnt);
        end
        checks++;
        if ({bc_read_req, bc_write_req} !== 2'b10) begin
            errors++;
            $display("FAIL read_req: got rd=%b wr=%b want rd=1 wr=0", bc_read_req, bc_write_req);
        end
        checks++;
        if (bc_addr !== 24'h000100) begin
            errors++;
            $display("FAIL read_addr: got %h want 000100", bc_addr);
        end
        @(negedge clk);
        checks++;
        if ({gnt, bc_read_req} !== 4'b0000) begin
            errors++;
            $display("FAIL read_one_cycle: got gnt=%b rd=%b want 000/0", gnt, bc_read_req);
        end
        wait_done(20, d, cyc);
        checks++;
        if (d !== 3'b010 || cyc != 4) begin
            errors++;
            $display("FAIL read_done: got done=%b after %0d want 010 after 4", d, cyc);
        end
        checks++;
        if (rdata !== 16'h1234) begin
            errors++;
            $display("FAIL read_rdata: got %h want 1234", rdata);
        end
        req = 3'b000;
        @(negedge clk);
        checks++;
        if (done !== 3'b000) begin
            errors++;
            $display("FAIL read_done_pulse: got %b want 000", done);
        end
    endtask

    task automatic test_byte_write();
        logic [NP-1:0] d;
        int            cyc;
        req             = 3'b100;
        we              = 3'b100;
        bsel            = 3'b100;
        bhigh           = 3'b100;
        addr[48 +: 24]  = 24'h00F002;
        wdata[32 +: 16] = 16'h00AB;
        rd_value        = 16'hDEAD;
        @(negedge clk);
        checks++;
        if ({gnt, bc_write_req, bc_read_req} !== 5'b10010) begin
            errors++;
            $display("FAIL write_gnt: got gnt=%b wr=%b rd=%b want 100/1/0",
                     gnt, bc_write_req, bc_read_req);
        end
        checks++;
        if ({bc_byte_sel, bc_byte_high, bc_wdata, bc_addr} !== {2'b11, 16'h00AB, 24'h00F002}) begin
            errors++;
            $display("FAIL write_ops: got bs=%b bh=%b wdata=%h addr=%h want 1 1 00ab 00f002",
                     bc_byte_sel, bc_byte_high, bc_wdata, bc_addr);
        end
        wait_done(20, d, cyc);
        checks++;
        if (d !== 3'b100 || cyc != 5) begin
            errors++;
            $display("FAIL write_done: got done=%b after %0d want 100 after 5", d, cyc);
        end
        checks++;
        if (rdata !== 16'h1234) begin
            errors++;
            $display("FAIL write_rdata_kept: got %h want 1234", rdata);
        end
        req   = 3'b000;
        we    = 3'b000;
        bsel  = 3'b000;
        bhigh = 3'b000;
        @(negedge clk);
    endtask

    task automatic test_arbitration();
        logic [NP-1:0] g;
        logic [NP-1:0] d;
        logic [NP-1:0] exp;
        int            cyc;
        req      = 3'b111;
        rd_value = 16'h0F0F;
        for (int i = 0; i < 6; i++) begin
            wait_gnt(20, g, cyc);
`ifdef MINI68K_ARB_RR_EN
            exp = 3'b001 << (i % 3);
`else
            exp = 3'b001;
`endif
            checks++;
            if (g !== exp) begin
                errors++;
                $display("FAIL arb_order[%0d]: got %b want %b", i, g, exp);
            end
            if (i > 0) begin
                checks++;
                if (cyc != 2) begin
                    errors++;
                    $display("FAIL back_to_back[%0d]: got gap %0d want 2", i, cyc);
                end
            end
            wait_done(20, d, cyc);
            checks++;
            if (d !== exp) begin
                errors++;
                $display("FAIL arb_done[%0d]: got %b want %b", i, d, exp);
            end
        end
        req = 3'b000;
    endtask

    task automatic test_busy();
        logic [NP-1:0] g;
        logic [NP-1:0] d;
        logic          seen;
        int            cyc;
        bc_busy = 1'b1;
        req     = 3'b001;
        seen    = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (gnt != '0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL busy_hold: got a grant while busy, want none");
        end
        bc_busy = 1'b0;
        wait_gnt(20, g, cyc);
        checks++;
        if (g !== 3'b001 || cyc != 1) begin
            errors++;
            $display("FAIL busy_release: got %b after %0d want 001 after 1", g, cyc);
        end
        wait_done(20, d, cyc);
        checks++;
        if (d !== 3'b001) begin
            errors++;
            $display("FAIL busy_done: got %b want 001", d);
        end
        req = 3'b000;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [NP-1:0] g;
        logic [NP-1:0] d;
        logic          seen;
        int            cyc;
        req      = 3'b100;
        bsel     = 3'b100;
        bhigh    = 3'b100;
        rd_value = 16'h5A5A;
        wait_gnt(20, g, cyc);
        checks++;
        if (g !== 3'b100) begin
            errors++;
            $display("FAIL mid_first_gnt: got %b want 100", g);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, done, bc_read_req, bc_write_req, bc_byte_sel, bc_byte_high} !== 10'b0) begin
            errors++;
            $display("FAIL mid_reset_ctrl: got gnt=%b done=%b rr=%b wr=%b bs=%b bh=%b want 0",
                     gnt, done, bc_read_req, bc_write_req, bc_byte_sel, bc_byte_high);
        end
        checks++;
        if ({rdata, bc_addr, bc_wdata} !== 56'h0) begin
            errors++;
            $display("FAIL mid_reset_data: got rdata=%h addr=%h wdata=%h want 0",
                     rdata, bc_addr, bc_wdata);
        end
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done != '0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_done: got a done pulse in reset, want none");
        end
        rst_n = 1'b1;
        wait_gnt(20, g, cyc);
        checks++;
        if (g !== 3'b100 || cyc != 1) begin
            errors++;
            $display("FAIL mid_regrant: got %b after %0d want 100 after 1", g, cyc);
        end
        wait_done(20, d, cyc);
        checks++;
        if (d !== 3'b100 || cyc != 5 || rdata !== 16'h5A5A) begin
            errors++;
            $display("FAIL mid_complete: got done=%b after %0d rdata=%h want 100 after 5 5a5a",
                     d, cyc, rdata);
        end
        req   = 3'b000;
        bsel  = 3'b000;
        bhigh = 3'b000;
        @(negedge clk);
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rst_n    = 1'b0;
        req      = '0;
        we       = '0;
        addr     = '0;
        wdata    = '0;
        bsel     = '0;
        bhigh    = '0;
        bc_busy  = 1'b0;
        rd_value = '0;
        test_reset();
        test_single_read();
        test_byte_write();
        test_arbitration();
        test_busy();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
